updown_counter: RTL and testbench

Parametrised up/down modulus counter; successor to the team's fixed 4-bit wrap-only counter. Width, modulus and wrap/saturate mode are set at elaboration. Count enable, direction and parallel load are set at run time, and the block reports terminal-count, wrap and overflow status. It serves as the general-purpose counting primitive for timers, address generators and event tallies in the chapter designs.

---
 rtl/updown_counter.sv | 78 +++++++
 tb/tb_updown_counter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// updown_counter: parametrised up/down modulus counter with parallel load,
// wrap/saturate boundary handling, terminal-count, wrap pulse and sticky
// overflow status. State updates on the falling edge of clock; clear is an
// asynchronous active-high reset that also masks tc.
//
// There is no valid/ready handshake on this block: enable and load are plain
// level-sampled controls, evaluated on every falling edge of clock.
module updown_counter #(
    parameter int WIDTH    = 4,
    parameter int MODULUS  = 16,
    parameter bit SATURATE = 1'b0
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             up_down,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap,
    output logic             overflow
);

    // Largest legal count. MODULUS <= 2**WIDTH, so MODULUS-1 always fits in
    // WIDTH bits; when MODULUS == 2**WIDTH this is all ones and the explicit
    // wrap to 0 coincides with natural binary rollover.
    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);

    logic             boundary;
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             overflow_next;

    // Boundary detection, load clamping and the combinational terminal count.
    always_comb begin
        boundary     = up_down ? (q == MAX_COUNT) : (q == '0);
        load_clamped = (load_value > MAX_COUNT) ? MAX_COUNT : load_value;
        tc           = enable & ~load & ~clear & boundary;
    end

    // Next-state selection: load beats enable, enable beats hold.
    always_comb begin
        q_next        = q;
        wrap_next     = 1'b0;
        overflow_next = overflow;
        if (load) begin
            q_next = load_clamped;
        end else if (enable) begin
            if (boundary) begin
                overflow_next = 1'b1;
                if (!SATURATE) begin
                    q_next    = up_down ? '0 : MAX_COUNT;
                    wrap_next = 1'b1;
                end
            end else begin
                // Away from a boundary q+1 <= MAX_COUNT and q-1 >= 0, so the
                // WIDTH-bit arithmetic can never overflow here.
                q_next = up_down ? (q + 1'b1) : (q - 1'b1);
            end
        end
    end

    // Falling-edge state register with asynchronous clear taking priority.
    always_ff @(negedge clock or posedge clear) begin
        if (clear) begin
            q        <= '0;
            wrap     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            q        <= q_next;
            wrap     <= wrap_next;
            overflow <= overflow_next;
        end
    end

endmodule

// File: tb/tb_updown_counter.sv
// Directed testbench for updown_counter. Three instances cover the
// MODULUS=10 wrap, MODULUS=10 saturate and MODULUS=16 full-range variants.
// Expected values are hand-computed in the stimulus below.
module tb_updown_counter;

  logic       clock;
  logic       clr [3];
  logic       en  [3];
  logic       ld  [3];
  logic       ud  [3];
  logic [3:0] lv  [3];
  logic [3:0] q   [3];
  logic       tc  [3];
  logic       wr  [3];
  logic       ov  [3];

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------------------------------------------------------- clock/reset
  initial clock = 1'b1;
  always #5 clock = ~clock;   // falling edges at 5, 15, 25, ...

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_wrap10 (
    .clock(clock), .clear(clr[0]), .enable(en[0]), .load(ld[0]),
    .load_value(lv[0]), .up_down(ud[0]), .q(q[0]), .tc(tc[0]),
    .wrap(wr[0]), .overflow(ov[0])
  );

  updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_sat10 (
    .clock(clock), .clear(clr[1]), .enable(en[1]), .load(ld[1]),
    .load_value(lv[1]), .up_down(ud[1]), .q(q[1]), .tc(tc[1]),
    .wrap(wr[1]), .overflow(ov[1])
  );

  updown_counter #(.WIDTH(4), .MODULUS(16), .SATURATE(1'b0)) u_full16 (
    .clock(clock), .clear(clr[2]), .enable(en[2]), .load(ld[2]),
    .load_value(lv[2]), .up_down(ud[2]), .q(q[2]), .tc(tc[2]),
    .wrap(wr[2]), .overflow(ov[2])
  );

  // ---------------------------------------------------------------- checking
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic drive(input int i, input logic e, input logic l, input logic u,
                       input logic [3:0] v);
    en[i] = e; ld[i] = l; ud[i] = u; lv[i] = v;
    #1;
  endtask

  // Advance past one falling edge; return 1 time unit after the next rising edge.
  task automatic tick();
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic expect_state(input string tag, input int i, input logic [3:0] eq,
                              input logic ew, input logic eo);
    check({tag, ".q"},    32'(q[i]),  32'(eq));
    check({tag, ".wrap"}, 32'(wr[i]), 32'(ew));
    check({tag, ".ovf"},  32'(ov[i]), 32'(eo));
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    for (int i = 0; i < 3; i++) begin
      clr[i] = 1'b1; en[i] = 1'b0; ld[i] = 1'b0; ud[i] = 1'b0; lv[i] = '0;
    end

    // Reset state; tc masked by clear even though q=0 counting down is a boundary.
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
    @(posedge clock); #1;
    expect_state("reset", 0, 4'd0, 1'b0, 1'b0);
    check("reset.tc", 32'(tc[0]), 32'd0);

    // Wrap up through 9 -> 0 with MODULUS=10.
    clr[0] = 1'b0;
    drive(0, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int k = 1; k <= 12; k++) begin
      check("up.tc", 32'(tc[0]), 32'(((k - 1) % 10) == 9));
      tick();
      expect_state("up", 0, 4'((k % 10)), k == 10, k >= 10);
    end

    // Load after overflow keeps overflow set.
    drive(0, 1'b0, 1'b1, 1'b1, 4'd7);
    tick();
    expect_state("load7", 0, 4'd7, 1'b0, 1'b1);

    // Clear mid-count for 5 ns spanning a falling edge; first count after release.
    drive(0, 1'b1, 1'b0, 1'b1, 4'd0);
    clr[0] = 1'b1;
    #1;
    expect_state("midclr", 0, 4'd0, 1'b0, 1'b0);
    check("midclr.tc", 32'(tc[0]), 32'd0);
    #4;
    clr[0] = 1'b0;
    tick();
    expect_state("postclr", 0, 4'd1, 1'b0, 1'b0);

    // Down through 0 -> 9 with wrap pulse.
    drive(0, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    expect_state("dn0", 0, 4'd0, 1'b0, 1'b0);
    check("dn0.tc", 32'(tc[0]), 32'd1);
    tick();
    expect_state("dnwrap", 0, 4'd9, 1'b1, 1'b1);
    tick();
    expect_state("dn8", 0, 4'd8, 1'b0, 1'b1);

    // Load has priority over enable; out-of-range load clamps to MODULUS-1.
    drive(0, 1'b1, 1'b1, 1'b1, 4'd4);
    tick();
    expect_state("ldprio", 0, 4'd4, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b1, 1'b1, 4'd13);
    tick();
    expect_state("ldclamp", 0, 4'd9, 1'b0, 1'b1);
    drive(0, 1'b1, 1'b0, 1'b1, 4'd0);
    check("ldclamp.tc", 32'(tc[0]), 32'd1);

    // Short (1 ns) clear pulse still resets fully.
    clr[0] = 1'b1;
    #1;
    clr[0] = 1'b0;
    #1;
    expect_state("shortclr", 0, 4'd0, 1'b0, 1'b0);

    // Clear rising on the same instant as the falling edge with q=9, tc=1.
    @(posedge clock); #1;
    drive(0, 1'b0, 1'b1, 1'b1, 4'd9);
    tick();
    expect_state("race.pre", 0, 4'd9, 1'b0, 1'b0);
    drive(0, 1'b1, 1'b0, 1'b1, 4'd0);
    check("race.pre.tc", 32'(tc[0]), 32'd1);
    #3;
    clr[0] = 1'b1;
    #1;
    expect_state("race", 0, 4'd0, 1'b0, 1'b0);
    check("race.tc", 32'(tc[0]), 32'd0);
    drive(0, 1'b0, 1'b0, 1'b0, 4'd0);

    // Saturate mode: up from 8 holds at 9, down from 1 holds at 0.
    @(posedge clock); #1;
    clr[1] = 1'b0;
    drive(1, 1'b0, 1'b1, 1'b1, 4'd8);
    tick();
    expect_state("sat.ld8", 1, 4'd8, 1'b0, 1'b0);
    drive(1, 1'b1, 1'b0, 1'b1, 4'd0);
    tick();
    expect_state("sat.up1", 1, 4'd9, 1'b0, 1'b0);
    check("sat.up.tc", 32'(tc[1]), 32'd1);
    tick();
    expect_state("sat.up2", 1, 4'd9, 1'b0, 1'b1);
    tick();
    expect_state("sat.up3", 1, 4'd9, 1'b0, 1'b1);
    drive(1, 1'b0, 1'b1, 1'b0, 4'd1);
    tick();
    expect_state("sat.ld1", 1, 4'd1, 1'b0, 1'b1);
    drive(1, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    expect_state("sat.dn1", 1, 4'd0, 1'b0, 1'b1);
    check("sat.dn.tc", 32'(tc[1]), 32'd1);
    tick();
    expect_state("sat.dn2", 1, 4'd0, 1'b0, 1'b1);

    // Full range MODULUS=16: 20 edges up, rollover 15 -> 0.
    clr[2] = 1'b0;
    drive(2, 1'b1, 1'b0, 1'b1, 4'd0);
    for (int k = 1; k <= 20; k++) begin
      tick();
      expect_state("full.up", 2, 4'((k % 16)), k == 16, k >= 16);
    end

    // Direction reversal from 3: 2, 1, 0, 15.
    drive(2, 1'b0, 1'b1, 1'b0, 4'd3);
    tick();
    check("full.ld3.q", 32'(q[2]), 32'd3);
    drive(2, 1'b1, 1'b0, 1'b0, 4'd0);
    tick();
    expect_state("rev2", 2, 4'd2, 1'b0, 1'b1);
    tick();
    expect_state("rev1", 2, 4'd1, 1'b0, 1'b1);
    tick();
    expect_state("rev0", 2, 4'd0, 1'b0, 1'b1);
    check("rev0.tc", 32'(tc[2]), 32'd1);
    tick();
    expect_state("rev15", 2, 4'd15, 1'b1, 1'b1);

    // ------------------------------------------------------------ report
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
